// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: request-to-send inhibit, bit-serial
// frame clocked by the device, ACK check and frame timeout.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 12000,
    parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_err,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int unsigned INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [INH_W-1:0] INH_PRE  = INH_W'((INHIBIT_CYCLES >= 2) ? INHIBIT_CYCLES - 2 : 0);
    localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQUEST,
        SEND,
        ACK,
        WAIT_IDLE
    } state_e;

    state_e           state_q, state_d;
    logic [7:0]       data_q, data_d;
    logic             parity_q, parity_d;
    logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic [3:0]       edge_cnt_q, edge_cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             clk_oe_q, clk_oe_d;
    logic             data_oe_q, data_oe_d;
    logic             ps2_clk_s1_q, ps2_clk_s1_d;
    logic             ps2_clk_s2_q, ps2_clk_s2_d;
    logic             ps2_clk_prev_q, ps2_clk_prev_d;
    logic             ps2_data_s1_q, ps2_data_s1_d;
    logic             ps2_data_s2_q, ps2_data_s2_d;
    logic             ps2_fall;
    logic             in_frame;

    assign ps2_fall = ps2_clk_prev_q & ~ps2_clk_s2_q;
    assign in_frame = (state_q == REQUEST) || (state_q == SEND) ||
                      (state_q == ACK) || (state_q == WAIT_IDLE);

    always_comb begin
        state_d        = state_q;
        data_d         = data_q;
        parity_d       = parity_q;
        inh_cnt_d      = inh_cnt_q;
        to_cnt_d       = to_cnt_q;
        edge_cnt_d     = edge_cnt_q;
        busy_d         = busy_q;
        done_d         = 1'b0;
        err_d          = 1'b0;
        clk_oe_d       = clk_oe_q;
        data_oe_d      = data_oe_q;
        ps2_clk_s1_d   = ps2_clk_in;
        ps2_clk_s2_d   = ps2_clk_s1_q;
        ps2_clk_prev_d = ps2_clk_s2_q;
        ps2_data_s1_d  = ps2_data_in;
        ps2_data_s2_d  = ps2_data_s1_q;

        case (state_q)
            IDLE: begin
                busy_d    = 1'b0;
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                if (tx_start) begin
                    data_d    = tx_data;
                    parity_d  = ~^tx_data;
                    inh_cnt_d = '0;
                    busy_d    = 1'b1;
                    clk_oe_d  = 1'b1;
                    data_oe_d = (INHIBIT_CYCLES == 1);
                    state_d   = INHIBIT;
                end
            end
            INHIBIT: begin
                if (inh_cnt_q == INH_LAST) begin
                    clk_oe_d   = 1'b0;
                    data_oe_d  = 1'b1;
                    to_cnt_d   = '0;
                    edge_cnt_d = '0;
                    state_d    = REQUEST;
                end else begin
                    inh_cnt_d = inh_cnt_q + 1'b1;
                    // Start bit goes out during the final inhibit cycle.
                    if ((INHIBIT_CYCLES >= 2) && (inh_cnt_q == INH_PRE)) begin
                        data_oe_d = 1'b1;
                    end
                end
            end
            REQUEST: begin
                state_d = SEND;
            end
            SEND: begin
                if (ps2_fall) begin
                    edge_cnt_d = edge_cnt_q + 1'b1;
                    if (edge_cnt_q < 4'd8) begin
                        data_oe_d = ~data_q[edge_cnt_q[2:0]];
                    end else if (edge_cnt_q == 4'd8) begin
                        data_oe_d = ~parity_q;
                    end else begin
                        data_oe_d = 1'b0;
                        state_d   = ACK;
                    end
                end
            end
            ACK: begin
                if (ps2_fall) begin
                    edge_cnt_d = edge_cnt_q + 1'b1;
                    if (ps2_data_s2_q) begin
                        err_d   = 1'b1;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        state_d = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                if (ps2_clk_s2_q && ps2_data_s2_q) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Timeout overrides any same-cycle transition so done and err stay exclusive.
        if (in_frame) begin
            if (to_cnt_q == TO_LIMIT) begin
                state_d   = IDLE;
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                busy_d    = 1'b0;
                done_d    = 1'b0;
                err_d     = 1'b1;
            end else begin
                to_cnt_d = to_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            data_q         <= '0;
            parity_q       <= 1'b0;
            inh_cnt_q      <= '0;
            to_cnt_q       <= '0;
            edge_cnt_q     <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
            clk_oe_q       <= 1'b0;
            data_oe_q      <= 1'b0;
            ps2_clk_s1_q   <= 1'b1;
            ps2_clk_s2_q   <= 1'b1;
            ps2_clk_prev_q <= 1'b1;
            ps2_data_s1_q  <= 1'b1;
            ps2_data_s2_q  <= 1'b1;
        end else begin
            state_q        <= state_d;
            data_q         <= data_d;
            parity_q       <= parity_d;
            inh_cnt_q      <= inh_cnt_d;
            to_cnt_q       <= to_cnt_d;
            edge_cnt_q     <= edge_cnt_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            err_q          <= err_d;
            clk_oe_q       <= clk_oe_d;
            data_oe_q      <= data_oe_d;
            ps2_clk_s1_q   <= ps2_clk_s1_d;
            ps2_clk_s2_q   <= ps2_clk_s2_d;
            ps2_clk_prev_q <= ps2_clk_prev_d;
            ps2_data_s1_q  <= ps2_data_s1_d;
            ps2_data_s2_q  <= ps2_data_s2_d;
        end
    end

    assign tx_busy     = busy_q;
    assign tx_done     = done_q;
    assign tx_err      = err_q;
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-collector PS/2 bus with a behavioural keyboard
// that clocks the frame, captures bits and optionally ACKs.
module tb_ps2_host_tx;

    localparam int unsigned INH = 50;
    localparam int unsigned TMO = 2000;
    localparam int unsigned H   = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] tx_data = '0;
    logic       tx_start = 1'b0;
    logic       tx_busy, tx_done, tx_err;
    logic       ps2_clk_oe, ps2_data_oe;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       ps2_clk_line, ps2_data_line;

    assign ps2_clk_line  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_line = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .tx_err     (tx_err),
        .ps2_clk_in (ps2_clk_line),
        .ps2_data_in(ps2_data_line),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int err_cnt = 0;

    typedef struct {
        logic [7:0] data;
        bit         ack;
        bit         poke;
        logic       exp_par;
        int         exp_done;
        int         exp_err;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Odd parity: the bit that makes the total count of ones odd.
    function automatic logic odd_parity(input logic [7:0] d);
        return ($countones(d) % 2) == 0;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            if (tx_done) done_cnt++;
            if (tx_err) err_cnt++;
            if (tx_done || tx_err) begin
                check("pulse_busy_low", {31'b0, tx_busy}, 32'd0);
                check("done_err_exclusive", {31'b0, tx_done & tx_err}, 32'd0);
            end
        end
    end

    task automatic start_and_inhibit(input logic [7:0] d);
        int   n;
        int   dcyc;
        logic last_doe;
        @(negedge clk);
        tx_data  = d;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        tx_data  = 8'($urandom);
        check("busy_after_accept", {31'b0, tx_busy}, 32'd1);
        n = 0;
        dcyc = 0;
        last_doe = 1'b0;
        while (ps2_clk_oe && n < int'(INH) + 10) begin
            n++;
            if (ps2_data_oe) dcyc++;
            last_doe = ps2_data_oe;
            @(negedge clk);
        end
        check("inhibit_len", n, INH);
        check("start_bit_cycles", dcyc, 1);
        check("start_bit_in_last", {31'b0, last_doe}, 32'd1);
        check("request_data_oe", {31'b0, ps2_data_oe}, 32'd1);
    endtask

    task automatic device(input bit ack, input bit poke, input int abort_edge,
                          output logic [9:0] cap, output bit aborted);
        cap = '0;
        aborted = 1'b0;
        repeat (5) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            dev_clk_low = 1'b1;
            repeat (H) @(negedge clk);
            if (abort_edge == i + 1) begin
                check("busy_before_reset", {31'b0, tx_busy}, 32'd1);
                rst = 1'b0;
                #1;
                check("rst_clk_oe", {31'b0, ps2_clk_oe}, 32'd0);
                check("rst_data_oe", {31'b0, ps2_data_oe}, 32'd0);
                check("rst_busy", {31'b0, tx_busy}, 32'd0);
                check("rst_no_pulse", {30'b0, tx_done, tx_err}, 32'd0);
                dev_clk_low = 1'b0;
                aborted = 1'b1;
                return;
            end
            dev_clk_low = 1'b0;
            repeat (H) @(negedge clk);
            cap[i] = ps2_data_line;
            if (poke && i == 3) begin
                tx_data  = 8'hAA;
                tx_start = 1'b1;
                @(negedge clk);
                tx_start = 1'b0;
            end
        end
        if (ack) dev_data_low = 1'b1;
        repeat (5) @(negedge clk);
        dev_clk_low = 1'b1;
        repeat (H) @(negedge clk);
        dev_clk_low = 1'b0;
        repeat (5) @(negedge clk);
        dev_data_low = 1'b0;
    endtask

    task automatic run_frame(input vec_t v, input int abort_edge);
        int         d0;
        int         e0;
        int         n;
        logic [9:0] cap;
        bit         ab;
        d0 = done_cnt;
        e0 = err_cnt;
        start_and_inhibit(v.data);
        device(v.ack, v.poke, abort_edge, cap, ab);
        if (ab) begin
            repeat (3) @(negedge clk);
            rst = 1'b1;
            repeat (30) @(negedge clk);
            check("abort_no_done", done_cnt - d0, 0);
            check("abort_no_err", err_cnt - e0, 0);
            check("abort_released", {30'b0, ps2_clk_oe, ps2_data_oe}, 32'd0);
            return;
        end
        check("wire_byte", {22'b0, cap[7:0]}, {24'b0, v.data});
        check("wire_parity", {31'b0, cap[8]}, {31'b0, v.exp_par});
        check("wire_stop", {31'b0, cap[9]}, 32'd1);
        n = 0;
        while (done_cnt == d0 && err_cnt == e0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("done_count", done_cnt - d0, v.exp_done);
        check("err_count", err_cnt - e0, v.exp_err);
        @(negedge clk);
        check("end_busy", {31'b0, tx_busy}, 32'd0);
        check("end_released", {30'b0, ps2_clk_oe, ps2_data_oe}, 32'd0);
        repeat (20) @(negedge clk);
        check("single_pulse", (done_cnt - d0) + (err_cnt - e0), 1);
    endtask

    task automatic run_timeout();
        int e0;
        int idx;
        e0 = err_cnt;
        start_and_inhibit(8'h5A);
        idx = 0;
        while (!tx_err && idx < int'(TMO) + 50) begin
            @(negedge clk);
            idx++;
        end
        check("timeout_latency", idx, TMO + 1);
        check("timeout_released", {30'b0, ps2_clk_oe, ps2_data_oe}, 32'd0);
        @(negedge clk);
        check("timeout_err_count", err_cnt - e0, 1);
        check("timeout_busy", {31'b0, tx_busy}, 32'd0);
    endtask

    initial begin
        vec_t v;
        vecs[0] = '{data: 8'hED, ack: 1'b1, poke: 1'b0, exp_par: 1'b0, exp_done: 0, exp_err: 0};
        vecs[1] = '{data: 8'h01, ack: 1'b1, poke: 1'b0, exp_par: 1'b0, exp_done: 0, exp_err: 0};
        vecs[2] = '{data: 8'hED, ack: 1'b0, poke: 1'b0, exp_par: 1'b0, exp_done: 0, exp_err: 0};
        vecs[3] = '{data: 8'hED, ack: 1'b1, poke: 1'b1, exp_par: 1'b0, exp_done: 0, exp_err: 0};
        for (int i = 4; i < 8; i++) begin
            vecs[i] = '{data: 8'($urandom), ack: bit'($urandom_range(0, 1)), poke: 1'b0,
                        exp_par: 1'b0, exp_done: 0, exp_err: 0};
        end
        for (int i = 0; i < 8; i++) begin
            vecs[i].exp_par  = odd_parity(vecs[i].data);
            vecs[i].exp_done = vecs[i].ack ? 1 : 0;
            vecs[i].exp_err  = vecs[i].ack ? 0 : 1;
        end

        repeat (3) @(negedge clk);
        check("reset_busy", {31'b0, tx_busy}, 32'd0);
        check("reset_done", {31'b0, tx_done}, 32'd0);
        check("reset_err", {31'b0, tx_err}, 32'd0);
        check("reset_clk_oe", {31'b0, ps2_clk_oe}, 32'd0);
        check("reset_data_oe", {31'b0, ps2_data_oe}, 32'd0);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            run_frame(vecs[i], 0);
        end

        v = vecs[0];
        run_frame(v, 5);
        v = '{data: 8'hF4, ack: 1'b1, poke: 1'b0, exp_par: odd_parity(8'hF4),
              exp_done: 1, exp_err: 0};
        run_frame(v, 0);

        run_timeout();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 SHALL have parameter INHIBIT_CYCLES, default 12000, clk cycles ps2_clk is held low to request-to-send (120 us at 100 MHz).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 2000000, max clk cycles from request release to frame completion (20 ms at 100 MHz).
REQ-003 clk  input  1  system clock; sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 tx_data  input  8  command byte to send to keyboard.
REQ-006 tx_start  input  1  one-cycle request; sampled only in IDLE.
REQ-007 tx_busy  output  1  high from accept until done/err pulse cycle.
REQ-008 tx_done  output  1  one-cycle pulse, frame ACKed by device.
REQ-009 tx_err  output  1  one-cycle pulse, NACK or timeout.
REQ-010 ps2_clk_in  input  1  PS/2 clock line level (asynchronous).
REQ-011 ps2_data_in  input  1  PS/2 data line level (asynchronous).
REQ-012 ps2_clk_oe  output  1  1 = pull PS/2 clock low; 0 = release.
REQ-013 ps2_data_oe  output  1  1 = pull PS/2 data low; 0 = release.

Function
REQ-014 SHALL synchronize ps2_clk_in and ps2_data_in through 2 flops; falling edge = previous synced clk 1, current 0.
REQ-015 SHALL implement states IDLE, INHIBIT, REQUEST, SEND, ACK, WAIT_IDLE; all outputs registered.
REQ-016 IDLE: both oe 0, tx_busy 0; tx_start=1 -> latch tx_data, parity = XNOR of 8 bits (odd parity), go INHIBIT, tx_busy=1 and ps2_clk_oe=1 from the next edge.
REQ-017 INHIBIT: ps2_clk_oe=1 for exactly INHIBIT_CYCLES cycles; ps2_data_oe set 1 in last INHIBIT cycle (start bit); then REQUEST.
REQ-018 REQUEST: ps2_clk_oe=0, ps2_data_oe=1; timeout counter cleared and starts; go SEND.
REQ-019 SEND: on falling edges 1..8 drive data bits 0..7 LSB first, edge 9 parity, edge 10 stop (release); bit value b drives ps2_data_oe = ~b.
REQ-020 ACK: on falling edge 11 sample synced data; 0 -> WAIT_IDLE; 1 -> tx_err pulse, IDLE.
REQ-021 WAIT_IDLE: wait until synced clk and data both 1, then tx_done pulse, IDLE.
REQ-022 Timeout counter exceeding TIMEOUT_CYCLES in REQUEST/SEND/ACK/WAIT_IDLE -> release both lines, tx_err pulse, IDLE.
REQ-023 tx_busy deasserts in the same cycle tx_done/tx_err pulses; done and err never simultaneous.
REQ-024 tx_start while tx_busy=1 SHALL be ignored; tx_data changes after accept SHALL not affect frame.
REQ-025 Falling-edge counter SHALL be 4 bits, cleared in REQUEST; no wrap within a frame.

Reset
REQ-026 rst=0 SHALL immediately force IDLE, ps2_clk_oe=0, ps2_data_oe=0, tx_busy=0, tx_done=0, tx_err=0, counters 0.
REQ-027 Reset mid-frame SHALL release both lines without completion pulses; first tx_start after release starts a fresh frame.

Verification
REQ-028 tx_data=0xED, device model clocks and ACKs -> clk_oe high 12000 cycles, data bits 1,0,1,1,0,1,1,1, parity 1, stop released, one tx_done.
REQ-029 tx_data=0x01 -> parity bit 0 sampled at edge 9; tx_done pulse; tx_err stays 0.
REQ-030 Device leaves data high at edge 11 -> one tx_err pulse, tx_busy 0 same cycle, lines released.
REQ-031 No device clocks after REQUEST -> tx_err exactly TIMEOUT_CYCLES+1 cycles after REQUEST, both oe 0.
REQ-032 rst low at falling edge 5 -> oe outputs 0 asynchronously, no pulses; next tx_start=0xF4 completes normally.
REQ-033 tx_start pulsed with 0xAA during frame of 0xED -> ignored; wire shows 0xED only, single tx_done.
